mem_wb_writeback: RTL and testbench
===================================

// Module: mem_wb_writeback
// PURPOSE
// MEM/WB pipeline register plus write-back select for the MIPS core. Sits directly upstream of the
// register bank and drives its a3/wd3/we3 write port. Latches the memory-stage result, then aligns
// and extends load data. Also exports a forwarding tap and a retired-instruction counter.
// PARAMETERS
// DATA_W  32  datapath width; the load-lane logic below is defined for 32 only
// REG_AW  5   register address width (32 architectural registers)
// PORTS
// clk              in   1       rising-edge clock
// rst              in   1       asynchronous reset, active-high
// stall            in   1       hold stage contents (hazard unit)
// flush            in   1       invalidate stage at next edge
// in_valid         in   1       MEM stage holds a real instruction
// in_reg_we        in   1       instruction writes a register
// in_dst           in   REG_AW  destination register number
// in_wb_sel        in   2       0=ALU, 1=load, 2=PC+8 link, 3=reserved (selects ALU)
// in_alu_result    in   DATA_W  ALU result; bits[1:0] are the load byte address
// in_load_data     in   DATA_W  raw aligned 32-bit word from data memory
// in_pc_plus8      in   DATA_W  link value for JAL/JALR
// in_load_size     in   2       0=byte, 1=half, 2=word, 3=word
// in_load_unsigned in   1       1=zero-extend (LBU/LHU), 0=sign-extend
// wb_a3            out  REG_AW  register bank write address
// wb_wd3           out  DATA_W  register bank write data
// wb_we3           out  1       register bank write enable
// fwd_valid        out  1       equals wb_we3; forwarding tap is live
// fwd_dst          out  REG_AW  equals wb_a3
// fwd_data         out  DATA_W  equals wb_wd3
// load_err         out  1       misaligned load is held in the stage
// retired_count    out  32      instructions retired, modulo 2^32
// BEHAVIOUR
// - Stage register (valid_q + all in_* fields) captures on posedge clk.
//   Priority at each edge: rst (async) > flush > stall > capture.
// - flush: valid_q<=0 and the other fields may hold. stall with no flush: everything holds.
// - flush and stall high together: flush wins, so valid_q<=0.
// - rst: valid_q, fields and retired_count go to 0 immediately, even mid-stall.
//   All outputs are then 0.
// - Outputs are combinational from the stage register, so latency is 1 cycle from in_* to wb_*.
// - Load lane, little-endian, with a = alu_q[1:0]:
//   - byte: byte lane a of load_q
//   - half: a[1]=0 gives [15:0], a[1]=1 gives [31:16]
//   - word: all 32 bits
//   - Sign- or zero-extend to 32 bits per unsigned_q.
// - Misaligned load: wb_sel=1 and either (half and a[0]=1) or (word and a!=0).
//   In that case load_err=1 and the write is suppressed.
// - wb_wd3 = mux(wb_sel) of alu_q, the extended load value, or pc8_q. It is valid whenever
//   valid_q=1, and is a don't-care when wb_we3=0 except under reset, where it is 0.
// - wb_we3 = valid_q & reg_we_q & (dst_q != 0) & !load_err. Writes to $0 are never issued.
// - wb_a3 = dst_q.
// - While stalled, the write re-asserts every cycle with the same a3/wd3. This is idempotent.
// - retired_count increments at each edge where valid_q=1 and stall=0 and rst=0, whether or
//   not the instruction writes a register and whether or not flush is high.
//   Instructions with load_err also count. Wraps from 0xFFFF_FFFF to 0.
// STRUCTURE
// - Shared package mips_pkg:
//   - typedef wb_sel_t enum {WB_ALU=0, WB_LOAD=1, WB_LINK=2}
//   - typedef ld_size_t enum {LD_B=0, LD_H=1, LD_W=2}
//   - localparams DATA_W and REG_AW
// - One combinational sub-module, load_align: (word, addr[1:0], size, unsigned) -> (data, misaligned).
// - This module holds the pipeline register, write-back mux and counter.
// TESTING
// 1. rst pulsed mid-stream with valid_q=1 -> wb_we3=0, wb_wd3=0 and retired_count=0 asynchronously,
//    with no edge needed.
// 2. ALU write-back: dst=5, sel=0, alu=0x1234_5678 -> next cycle wb_we3=1, a3=5, wd3=0x1234_5678,
//    and retired_count goes +1 on the following edge.
// 3. Loads with word 0x80FF_7F01:
//    - LB a=1 -> 0x0000_007F
//    - LB a=3 -> 0xFFFF_FF80
//    - LHU a=2 -> 0x0000_80FF
//    - LH a=0 -> 0x0000_7F01
//    - LW a=0 -> 0x80FF_7F01
// 4. Misaligned: LH a=1 -> load_err=1 and wb_we3=0. LW a=2 -> same.
// 5. dst=0 with reg_we=1 -> wb_we3=0. JAL with pc8=0x0040_0008, dst=31 -> wd3=0x0040_0008.
// 6. stall held 3 cycles -> outputs constant and count unchanged. flush+stall together ->
//    wb_we3=0 next cycle. Preload count 0xFFFF_FFFF and retire one instruction -> count=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS core back end.
//   DATA_W    datapath width (load-lane logic assumes 32)
//   REG_AW    register address width (32 architectural registers)
//   wb_sel_t  write-back source select; encoding 3 is reserved and behaves as ALU
//   ld_size_t load size; encoding 3 behaves as word
//   ext8/ext16 sign- or zero-extension helpers used by the load aligner
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_LINK = 2'd2
  } wb_sel_t;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2
  } ld_size_t;

  function automatic logic [31:0] ext8(input logic [7:0] v, input logic uns);
    return uns ? {24'd0, v} : {{24{v[7]}}, v};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic uns);
    return uns ? {16'd0, v} : {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: combinational little-endian load lane selection and extension.
//   word_i       raw aligned 32-bit word from data memory
//   addr_i       low two bits of the byte address
//   size_i       0=byte, 1=half, 2/3=word
//   unsigned_i   1=zero-extend, 0=sign-extend
//   data_o       aligned, extended load value
//   misaligned_o half at an odd address, or word at a non-zero offset
module load_align
  import mips_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [1:0]        addr_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] data_o,
  output logic              misaligned_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and half-word lanes.
  always_comb begin
    case (addr_i)
      2'd0:    byte_s = word_i[7:0];
      2'd1:    byte_s = word_i[15:8];
      2'd2:    byte_s = word_i[23:16];
      default: byte_s = word_i[31:24];
    endcase
    half_s = addr_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Extend by size; size 3 is treated as a full word.
  always_comb begin
    case (size_i)
      LD_B: begin
        data_o       = ext8(byte_s, unsigned_i);
        misaligned_o = 1'b0;
      end
      LD_H: begin
        data_o       = ext16(half_s, unsigned_i);
        misaligned_o = addr_i[0];
      end
      default: begin
        data_o       = word_i;
        misaligned_o = (addr_i != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: MEM/WB pipeline register, write-back select and retire counter.
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   stall, flush        hold the stage / invalidate the stage (flush wins)
//   in_*                memory-stage instruction fields
//   wb_a3/wb_wd3/wb_we3 register bank write port
//   fwd_valid/dst/data  forwarding tap, identical to the write port
//   load_err            the held instruction is a misaligned load (write suppressed)
//   retired_count       instructions retired, modulo 2^32
module mem_wb_writeback
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_we,
  input  logic [REG_AW-1:0] in_dst,
  input  logic [1:0]        in_wb_sel,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_load_data,
  input  logic [DATA_W-1:0] in_pc_plus8,
  input  logic [1:0]        in_load_size,
  input  logic              in_load_unsigned,
  output logic [REG_AW-1:0] wb_a3,
  output logic [DATA_W-1:0] wb_wd3,
  output logic              wb_we3,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_dst,
  output logic [DATA_W-1:0] fwd_data,
  output logic              load_err,
  output logic [31:0]       retired_count
);

  logic              valid_q, valid_d;
  logic              reg_we_q, reg_we_d;
  logic [REG_AW-1:0] dst_q, dst_d;
  logic [1:0]        wb_sel_q, wb_sel_d;
  logic [DATA_W-1:0] alu_q, alu_d;
  logic [DATA_W-1:0] load_q, load_d;
  logic [DATA_W-1:0] pc8_q, pc8_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       retired_count_q, retired_count_d;

  logic [DATA_W-1:0] load_val_s;
  logic              misaligned_s;

  load_align u_load_align (
    .word_i       (load_q),
    .addr_i       (alu_q[1:0]),
    .size_i       (size_q),
    .unsigned_i   (uns_q),
    .data_o       (load_val_s),
    .misaligned_o (misaligned_s)
  );

  // Next-state for the stage register and the retire counter.
  always_comb begin
    valid_d  = valid_q;
    reg_we_d = reg_we_q;
    dst_d    = dst_q;
    wb_sel_d = wb_sel_q;
    alu_d    = alu_q;
    load_d   = load_q;
    pc8_d    = pc8_q;
    size_d   = size_q;
    uns_d    = uns_q;
    if (flush) begin
      // Only the valid bit matters; the payload may hold.
      valid_d = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
    end else begin
      valid_d  = in_valid;
      reg_we_d = in_reg_we;
      dst_d    = in_dst;
      wb_sel_d = in_wb_sel;
      alu_d    = in_alu_result;
      load_d   = in_load_data;
      pc8_d    = in_pc_plus8;
      size_d   = in_load_size;
      uns_d    = in_load_unsigned;
    end
    // An instruction retires when it leaves the stage, flushed or not.
    if (valid_q && !stall) begin
      retired_count_d = retired_count_q + 32'd1;
    end else begin
      retired_count_d = retired_count_q;
    end
  end

  // Stage and counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q         <= 1'b0;
      reg_we_q        <= 1'b0;
      dst_q           <= '0;
      wb_sel_q        <= 2'd0;
      alu_q           <= '0;
      load_q          <= '0;
      pc8_q           <= '0;
      size_q          <= 2'd0;
      uns_q           <= 1'b0;
      retired_count_q <= 32'd0;
    end else begin
      valid_q         <= valid_d;
      reg_we_q        <= reg_we_d;
      dst_q           <= dst_d;
      wb_sel_q        <= wb_sel_d;
      alu_q           <= alu_d;
      load_q          <= load_d;
      pc8_q           <= pc8_d;
      size_q          <= size_d;
      uns_q           <= uns_d;
      retired_count_q <= retired_count_d;
    end
  end

  // Write-back data select; reserved select 3 falls through to ALU.
  // All-zero stage contents make the write data zero under reset.
  always_comb begin
    case (wb_sel_q)
      WB_LOAD: wb_wd3 = load_val_s;
      WB_LINK: wb_wd3 = pc8_q;
      default: wb_wd3 = alu_q;
    endcase
  end

  assign load_err      = valid_q & (wb_sel_q == WB_LOAD) & misaligned_s;
  assign wb_we3        = valid_q & reg_we_q & (dst_q != '0) & ~load_err;
  assign wb_a3         = dst_q;
  assign fwd_valid     = wb_we3;
  assign fwd_dst       = wb_a3;
  assign fwd_data      = wb_wd3;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
module tb_mem_wb_writeback;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, in_reg_we, in_load_unsigned;
  logic [4:0]  in_dst;
  logic [1:0]  in_wb_sel, in_load_size;
  logic [31:0] in_alu_result, in_load_data, in_pc_plus8;
  logic [4:0]  wb_a3, fwd_dst;
  logic [31:0] wb_wd3, fwd_data, retired_count;
  logic        wb_we3, fwd_valid, load_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic        err;
    logic [4:0]  a3;
    logic [31:0] wd3;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mem_wb_writeback dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_reg_we(in_reg_we), .in_dst(in_dst),
    .in_wb_sel(in_wb_sel), .in_alu_result(in_alu_result),
    .in_load_data(in_load_data), .in_pc_plus8(in_pc_plus8),
    .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .wb_a3(wb_a3), .wb_wd3(wb_wd3), .wb_we3(wb_we3),
    .fwd_valid(fwd_valid), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
    .load_err(load_err), .retired_count(retired_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [4:0] dst,
                       input logic [1:0] sel, input logic [31:0] alu,
                       input logic [31:0] ld, input logic [31:0] pc8,
                       input logic [1:0] sz, input logic uns);
    in_valid = v; in_reg_we = we; in_dst = dst; in_wb_sel = sel;
    in_alu_result = alu; in_load_data = ld; in_pc_plus8 = pc8;
    in_load_size = sz; in_load_unsigned = uns;
  endtask

  task automatic expect_out(input logic we, input logic err, input logic [4:0] a3,
                            input logic [31:0] wd3);
    exp_t e;
    e.we = we; e.err = err; e.a3 = a3; e.wd3 = wd3;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0);
    stall = 1'b0; flush = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: compare against the scoreboard whenever the stage presents a write or an error.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (wb_we3 || load_err) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: we=%0b err=%0b a3=%0d wd3=%h, nothing expected",
                   wb_we3, load_err, wb_a3, wb_wd3);
        end else begin
          e = sb_q.pop_front();
          if ({wb_we3, load_err, wb_a3, fwd_valid, fwd_dst} !== {e.we, e.err, e.a3, e.we, e.a3}) begin
            errors++;
            $display("FAIL ctrl: we=%0b err=%0b a3=%0d fwd_v=%0b fwd_dst=%0d expected we=%0b err=%0b a3=%0d",
                     wb_we3, load_err, wb_a3, fwd_valid, fwd_dst, e.we, e.err, e.a3);
          end
          if (e.we) begin
            checks++;
            if (wb_wd3 !== e.wd3 || fwd_data !== e.wd3) begin
              errors++;
              $display("FAIL wd3: got %h fwd %h expected %h", wb_wd3, fwd_data, e.wd3);
            end
          end
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "timeout");
  end

  localparam logic [31:0] LDW = 32'h80FF_7F01;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0);
    repeat (2) @(negedge clk);
    chk("reset_we3", {31'd0, wb_we3}, 32'd0);
    chk("reset_wd3", wb_wd3, 32'd0);
    chk("reset_count", retired_count, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ALU write-back; counter bumps on the edge after capture.
    drive(1'b1, 1'b1, 5'd5, WB_ALU, 32'h1234_5678, 32'd0, 32'd0, LD_W, 1'b0);
    expect_out(1'b1, 1'b0, 5'd5, 32'h1234_5678);
    @(negedge clk);
    chk("count_after_capture", retired_count, 32'd0);
    idle();
    chk("count_alu_retired", retired_count, 32'd1);

    // Loads from word 0x80FF_7F01.
    drive(1'b1, 1'b1, 5'd8,  WB_LOAD, 32'h1000_0001, LDW, 32'd0, LD_B, 1'b0);
    expect_out(1'b1, 1'b0, 5'd8, 32'h0000_007F);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd9,  WB_LOAD, 32'h1000_0003, LDW, 32'd0, LD_B, 1'b0);
    expect_out(1'b1, 1'b0, 5'd9, 32'hFFFF_FF80);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd10, WB_LOAD, 32'h1000_0002, LDW, 32'd0, LD_H, 1'b1);
    expect_out(1'b1, 1'b0, 5'd10, 32'h0000_80FF);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd11, WB_LOAD, 32'h1000_0000, LDW, 32'd0, LD_H, 1'b0);
    expect_out(1'b1, 1'b0, 5'd11, 32'h0000_7F01);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd12, WB_LOAD, 32'h1000_0000, LDW, 32'd0, LD_W, 1'b0);
    expect_out(1'b1, 1'b0, 5'd12, 32'h80FF_7F01);
    @(negedge clk);
    idle();
    chk("count_loads", retired_count, 32'd6);

    // Misaligned loads: error flagged, write suppressed, still retired.
    drive(1'b1, 1'b1, 5'd13, WB_LOAD, 32'h1000_0001, LDW, 32'd0, LD_H, 1'b0);
    expect_out(1'b0, 1'b1, 5'd13, 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd14, WB_LOAD, 32'h1000_0002, LDW, 32'd0, LD_W, 1'b0);
    expect_out(1'b0, 1'b1, 5'd14, 32'd0);
    @(negedge clk);
    chk("misaligned_we3", {31'd0, wb_we3}, 32'd0);
    idle();
    chk("count_misaligned", retired_count, 32'd8);

    // $0 write suppressed (no expectation pushed), JAL link, reserved select.
    drive(1'b1, 1'b1, 5'd0, WB_ALU, 32'h0000_1111, 32'd0, 32'd0, LD_W, 1'b0);
    @(negedge clk);
    chk("dst0_we3", {31'd0, wb_we3}, 32'd0);
    drive(1'b1, 1'b1, 5'd31, WB_LINK, 32'hDEAD_BEEF, 32'd0, 32'h0040_0008, LD_W, 1'b0);
    expect_out(1'b1, 1'b0, 5'd31, 32'h0040_0008);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd7, 2'd3, 32'h0BAD_F00D, LDW, 32'h0040_0010, LD_W, 1'b0);
    expect_out(1'b1, 1'b0, 5'd7, 32'h0BAD_F00D);
    @(negedge clk);
    idle();
    chk("count_misc", retired_count, 32'd11);

    // Stall three cycles: same write re-presented, count frozen.
    drive(1'b1, 1'b1, 5'd3, WB_ALU, 32'hA5A5_0003, 32'd0, 32'd0, LD_W, 1'b0);
    expect_out(1'b1, 1'b0, 5'd3, 32'hA5A5_0003);
    @(negedge clk);
    stall = 1'b1;
    drive(1'b1, 1'b1, 5'd4, WB_ALU, 32'h0000_0B0B, 32'd0, 32'd0, LD_W, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_out(1'b1, 1'b0, 5'd3, 32'hA5A5_0003);
      @(negedge clk);
    end
    chk("count_stalled", retired_count, 32'd11);
    stall = 1'b0;
    expect_out(1'b1, 1'b0, 5'd4, 32'h0000_0B0B);
    @(negedge clk);
    chk("count_unstall", retired_count, 32'd12);
    // flush and stall together: stage invalid, nothing retires.
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 1'b1, 5'd6, WB_ALU, 32'h0000_0C0C, 32'd0, 32'd0, LD_W, 1'b0);
    @(negedge clk);
    chk("flush_stall_we3", {31'd0, wb_we3}, 32'd0);
    idle();
    chk("count_flush_stall", retired_count, 32'd12);

    // flush alone still retires the held instruction.
    drive(1'b1, 1'b1, 5'd2, WB_ALU, 32'h0000_0E0E, 32'd0, 32'd0, LD_W, 1'b0);
    expect_out(1'b1, 1'b0, 5'd2, 32'h0000_0E0E);
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, 1'b1, 5'd1, WB_ALU, 32'h0000_0F0F, 32'd0, 32'd0, LD_W, 1'b0);
    @(negedge clk);
    chk("flush_we3", {31'd0, wb_we3}, 32'd0);
    idle();
    chk("count_flush", retired_count, 32'd13);

    // Asynchronous reset while a valid write is held, between edges.
    drive(1'b1, 1'b1, 5'd17, WB_ALU, 32'h5555_AAAA, 32'd0, 32'd0, LD_W, 1'b0);
    expect_out(1'b1, 1'b0, 5'd17, 32'h5555_AAAA);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_we3", {31'd0, wb_we3}, 32'd0);
    chk("async_rst_wd3", wb_wd3, 32'd0);
    chk("async_rst_count", retired_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();

    // Counter wrap from 0xFFFF_FFFF.
    force dut.retired_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count_q;
    chk("count_preload", retired_count, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(1'b1, 1'b1, 5'd20, WB_ALU, 32'h0000_0020, 32'd0, 32'd0, LD_W, 1'b0);
    expect_out(1'b1, 1'b0, 5'd20, 32'h0000_0020);
    @(negedge clk);
    idle();
    chk("count_wrap", retired_count, 32'd0);

    repeat (2) idle();
    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
